// File: rtl/rv32_core_pkg.sv
// Shared types and constants for the basic RV32 core pipeline stages.
// The fetch state encoding lives here so exec-side debug logic can decode it.
package rv32_core_pkg;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    VALID,
    DROP,
    HALT
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          ILEN_BYTES = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in flight,
// hands one instruction at a time to exec and follows exec redirects/halts.
module fetch_unit
  import rv32_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_valid,
  input  logic               e_otp_rdy,
  input  logic               e_j_flag,
  input  logic [31:0]        e_pc_next,
  input  logic               halted,
  output logic [31:0]        f_instr,
  output logic [31:0]        f_pc,
  output logic               e_inp_rdy,
  output logic               f_misalign
);

  fetch_state_e state, state_next;
  logic [31:0]  pc_next;
  logic [31:0]  instr_next;
  logic         inp_rdy_next;
  logic         misalign_next;
  logic         target_misaligned;

  assign target_misaligned = (e_pc_next[1:0] != 2'b00);

  // Gated by rst_n so memory never sees a request while the core is held in reset.
  assign imem_req  = (state == REQ) && rst_n;
  assign imem_addr = f_pc[IMEM_AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= REQ;
      f_pc       <= RESET_PC;
      f_instr    <= NOP_INSTR;
      e_inp_rdy  <= 1'b0;
      f_misalign <= 1'b0;
    end else begin
      state      <= state_next;
      f_pc       <= pc_next;
      f_instr    <= instr_next;
      e_inp_rdy  <= inp_rdy_next;
      f_misalign <= misalign_next;
    end
  end

  // Priority: halted > misaligned redirect > redirect > consume > memory response.
  always_comb begin
    state_next    = state;
    pc_next       = f_pc;
    instr_next    = f_instr;
    inp_rdy_next  = e_inp_rdy;
    misalign_next = f_misalign;

    if (state == HALT) begin
      inp_rdy_next = 1'b0;
    end else if (halted) begin
      inp_rdy_next = 1'b0;
      state_next   = HALT;
    end else if (e_j_flag && target_misaligned) begin
      misalign_next = 1'b1;
      pc_next       = e_pc_next;
      inp_rdy_next  = 1'b0;
      state_next    = HALT;
    end else if (e_j_flag) begin
      pc_next      = e_pc_next;
      inp_rdy_next = 1'b0;
      // A request already in flight must have its response thrown away.
      unique case (state)
        REQ:     state_next = DROP;
        WAIT:    state_next = imem_valid ? REQ : DROP;
        DROP:    state_next = imem_valid ? REQ : DROP;
        default: state_next = REQ;
      endcase
    end else begin
      unique case (state)
        REQ: state_next = WAIT;
        WAIT: begin
          if (imem_valid) begin
            instr_next   = imem_rdata;
            inp_rdy_next = 1'b1;
            state_next   = VALID;
          end
        end
        VALID: begin
          if (e_otp_rdy) begin
            pc_next      = f_pc + 32'(ILEN_BYTES);
            inp_rdy_next = 1'b0;
            state_next   = REQ;
          end
        end
        DROP: begin
          if (imem_valid) begin
            state_next = REQ;
          end
        end
        default: state_next = HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instruction memory of
// programmable latency and a scoreboard of expected {pc, instr} presentations.
module tb_fetch_unit;
  import rv32_core_pkg::*;

  localparam int IMEM_AW = 10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } present_t;

  logic               clk;
  logic               rst_n;
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               imem_valid;
  logic               e_otp_rdy;
  logic               e_j_flag;
  logic [31:0]        e_pc_next;
  logic               halted;
  logic [31:0]        f_instr;
  logic [31:0]        f_pc;
  logic               e_inp_rdy;
  logic               f_misalign;

  int       errors = 0;
  int       checks = 0;
  int       mem_latency = 1;
  int       mem_cnt;
  present_t sb_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(IMEM_AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .e_otp_rdy  (e_otp_rdy),
    .e_j_flag   (e_j_flag),
    .e_pc_next  (e_pc_next),
    .halted     (halted),
    .f_instr    (f_instr),
    .f_pc       (f_pc),
    .e_inp_rdy  (e_inp_rdy),
    .f_misalign (f_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input int idx);
    if (idx == 0) return 32'h0050_0093;
    return 32'hA000_0013 | (32'(idx) << 8);
  endfunction

  // Memory model: response appears mem_latency cycles after the request cycle.
  logic [31:0] mem_data;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt    <= 0;
      imem_valid <= 1'b0;
      imem_rdata <= 32'h0;
      mem_data   <= 32'h0;
    end else begin
      imem_valid <= 1'b0;
      if (mem_cnt == 1) begin
        imem_valid <= 1'b1;
        imem_rdata <= mem_data;
        mem_cnt    <= 0;
      end else if (mem_cnt > 1) begin
        mem_cnt <= mem_cnt - 1;
      end
      if (imem_req) begin
        if (mem_latency == 1) begin
          imem_valid <= 1'b1;
          imem_rdata <= memWord(int'(imem_addr));
          mem_cnt    <= 0;
        end else begin
          mem_data <= memWord(int'(imem_addr));
          mem_cnt  <= mem_latency - 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic otp, input logic jf,
                               input logic [31:0] target, input logic hlt);
    e_otp_rdy = otp;
    e_j_flag  = jf;
    e_pc_next = target;
    halted    = hlt;
  endtask

  // Waits for the next presentation, checking any request address on the way.
  task automatic fetchOne(input string tag, input logic [31:0] exp_pc, input int exp_cycles);
    present_t exp;
    int n;
    bit got;
    sb_q.push_back('{pc: exp_pc, instr: memWord(int'(exp_pc[11:2]))});
    n = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (imem_req) checkOutput({tag, "_req_addr"}, 32'(imem_addr), 32'(exp_pc[11:2]));
      if (e_inp_rdy) got = 1'b1;
    end
    checkOutput({tag, "_present"}, 32'(got), 32'd1);
    checkOutput({tag, "_latency"}, n, exp_cycles);
    if (got && sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      checkOutput({tag, "_pc"}, f_pc, exp.pc);
      checkOutput({tag, "_instr"}, f_instr, exp.instr);
    end
  endtask

  task automatic countReqs(input int cycles, output int reqs);
    reqs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (imem_req || e_inp_rdy) reqs++;
    end
  endtask

  initial begin
    int reqs;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_rdy", 32'(e_inp_rdy), 32'd0);
    checkOutput("rst_pc", f_pc, 32'h0);
    checkOutput("rst_instr", f_instr, NOP_INSTR);
    checkOutput("rst_misalign", 32'(f_misalign), 32'd0);

    rst_n = 1'b1;
    #1;
    checkOutput("first_req", 32'(imem_req), 32'd1);
    checkOutput("first_addr", 32'(imem_addr), 32'h0);
    fetchOne("word0", 32'h0, 2);

    // Exec stall: presentation must stay frozen with no new requests.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_pc", f_pc, 32'h0);
      checkOutput("stall_instr", f_instr, 32'h0050_0093);
      checkOutput("stall_rdy", 32'(e_inp_rdy), 32'd1);
      checkOutput("stall_req", 32'(imem_req), 32'd0);
    end

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    fetchOne("seq4", 32'h4, 3);
    fetchOne("seq8", 32'h8, 3);

    // Redirect while an instruction is presented.
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("redir_rdy", 32'(e_inp_rdy), 32'd0);
    checkOutput("redir_req", 32'(imem_req), 32'd1);
    checkOutput("redir_addr", 32'(imem_addr), 32'h010);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    fetchOne("redir40", 32'h40, 2);

    // Redirect while waiting on a slow memory: the stale word must be dropped.
    mem_latency = 3;
    @(negedge clk);
    checkOutput("slow_req", 32'(imem_req), 32'd1);
    checkOutput("slow_addr", 32'(imem_addr), 32'h011);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("drop_pc", f_pc, 32'h80);
    checkOutput("drop_rdy", 32'(e_inp_rdy), 32'd0);
    checkOutput("drop_req", 32'(imem_req), 32'd0);
    fetchOne("redir80", 32'h80, 6);

    // Halt while valid.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("halt_rdy", 32'(e_inp_rdy), 32'd0);
    countReqs(20, reqs);
    checkOutput("halt_quiet", reqs, 0);

    rst_n = 1'b0;
    mem_latency = 1;
    @(negedge clk);
    checkOutput("rst2_pc", f_pc, 32'h0);
    checkOutput("rst2_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst2_first_req", 32'(imem_req), 32'd1);
    fetchOne("rst2_word0", 32'h0, 2);

    // Misaligned redirect target.
    applyStimulus(1'b0, 1'b1, 32'h42, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("mis_flag", 32'(f_misalign), 32'd1);
    checkOutput("mis_pc", f_pc, 32'h42);
    checkOutput("mis_rdy", 32'(e_inp_rdy), 32'd0);
    countReqs(10, reqs);
    checkOutput("mis_quiet", reqs, 0);
    checkOutput("mis_sticky", 32'(f_misalign), 32'd1);

    checkOutput("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
